// File: rtl/stim_gen.sv
// stim_gen: drives a/b/cin vectors for the adder bench, either an exhaustive sweep of
// {cin,a,b} or a fixed-length LFSR run, with start/hold/valid/done handshaking.
module stim_gen #(
  parameter int          n     = 4,
  parameter logic [31:0] SEED  = 32'h0000_0001,
  parameter int          NRAND = 256
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          mode,
  input  logic          hold,
  output logic [n-1:0]  a,
  output logic [n-1:0]  b,
  output logic          cin,
  output logic          valid,
  output logic          busy,
  output logic          done,
  output logic [31:0]   vec_count
);

  localparam int          VW       = 2 * n + 1;
  localparam logic [31:0] SEED_EFF = (SEED == 32'h0) ? 32'h0000_0001 : SEED;
  localparam logic [31:0] LEN_EXH  = 32'd1 << VW;
  localparam logic [31:0] LEN_RND  = 32'(NRAND);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t         state;
  logic           mode_q;
  logic [31:0]    idx;
  logic [31:0]    lfsr;
  logic [31:0]    lfsr_next;
  logic [31:0]    idx_next;
  logic [31:0]    last_idx;
  logic [VW-1:0]  vec;

  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return (s >> 1) ^ (s[0] ? 32'h8020_0003 : 32'h0);
  endfunction

  assign lfsr_next = lfsr_step(lfsr);
  assign idx_next  = idx + 32'd1;
  // The index is 32 bits wide so the full-width last-vector compare can never wrap.
  assign last_idx  = mode_q ? (LEN_RND - 32'd1) : (LEN_EXH - 32'd1);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      mode_q    <= 1'b0;
      idx       <= '0;
      lfsr      <= SEED_EFF;
      vec       <= '0;
      valid     <= 1'b0;
      vec_count <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state     <= RUN;
            mode_q    <= mode;
            idx       <= '0;
            lfsr      <= SEED_EFF;
            vec       <= mode ? SEED_EFF[VW-1:0] : '0;
            valid     <= 1'b1;
            vec_count <= 32'd1;
          end else begin
            valid <= 1'b0;
          end
        end
        RUN: begin
          if (hold) begin
            valid <= 1'b0;
          end else if (idx == last_idx) begin
            state <= DONE;
            valid <= 1'b0;
          end else begin
            idx   <= idx_next;
            lfsr  <= lfsr_next;
            vec   <= mode_q ? lfsr_next[VW-1:0] : idx_next[VW-1:0];
            valid <= 1'b1;
            if (vec_count != 32'hFFFF_FFFF)
              vec_count <= vec_count + 32'd1;
          end
        end
        default: begin
          state <= IDLE;
          valid <= 1'b0;
        end
      endcase
    end
  end

  assign {cin, a, b} = vec;
  assign busy = (state == RUN);
  assign done = (state == DONE);

endmodule

// File: tb/tb_stim_gen.sv
// tb_stim_gen: two stim_gen instances (short and long random runs) checked every cycle
// against a sequence-level model, plus directed literal checks of the key scenarios.
module tb_stim_gen;

  logic        clk = 1'b0;
  logic        rst_n, start, mode, hold;
  logic [3:0]  a4, b4, al, bl;
  logic        cin4, valid4, busy4, done4;
  logic        cinl, validl, busyl, donel;
  logic [31:0] cnt4, cntl;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  logic [31:0] lfsr_tab [300];
  int unsigned nrand_of [2] = '{4, 300};

  // Model: a run is just an index k into a known sequence; outputs follow from k.
  bit m_run [2], m_done [2], m_mode [2], m_valid [2];
  int m_k [2];

  always #5 clk = ~clk;

  stim_gen #(.n(4), .SEED(32'h0000_0001), .NRAND(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .hold(hold),
    .a(a4), .b(b4), .cin(cin4), .valid(valid4), .busy(busy4), .done(done4),
    .vec_count(cnt4)
  );

  stim_gen #(.n(4), .SEED(32'h0000_0000), .NRAND(300)) u_dutl (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .hold(hold),
    .a(al), .b(bl), .cin(cinl), .valid(validl), .busy(busyl), .done(donel),
    .vec_count(cntl)
  );

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int unsigned run_len(input int i);
    return m_mode[i] ? nrand_of[i] : 32'd512;
  endfunction

  function automatic logic [8:0] vec_at(input int i, input int k);
    logic [31:0] kk;
    kk = k;
    return m_mode[i] ? lfsr_tab[k][8:0] : kk[8:0];
  endfunction

  task automatic model_step(input int i);
    if (!rst_n) begin
      m_run[i] = 0; m_done[i] = 0; m_valid[i] = 0; m_k[i] = 0; m_mode[i] = 0;
    end else if (!m_run[i]) begin
      if (start) begin
        m_run[i] = 1; m_done[i] = 0; m_mode[i] = mode; m_k[i] = 0; m_valid[i] = 1;
      end else begin
        m_valid[i] = 0;
      end
    end else if (hold) begin
      m_valid[i] = 0;
    end else if (m_k[i] == int'(run_len(i)) - 1) begin
      m_run[i] = 0; m_done[i] = 1; m_valid[i] = 0;
    end else begin
      m_k[i]++;
      m_valid[i] = 1;
    end
  endtask

  task automatic check_inst(input int i, input logic [8:0] v, input logic val,
                            input logic bsy, input logic dn, input logic [31:0] cnt);
    logic [8:0]  ev;
    logic [31:0] ec;
    ev = (m_run[i] || m_done[i]) ? vec_at(i, m_k[i]) : 9'h0;
    ec = m_run[i] ? 32'(m_k[i] + 1) : (m_done[i] ? 32'(run_len(i)) : 32'h0);
    check_output($sformatf("u%0d_vec", i), 32'(v), 32'(ev));
    check_output($sformatf("u%0d_valid", i), 32'(val), 32'(m_valid[i]));
    check_output($sformatf("u%0d_busy", i), 32'(bsy), 32'(m_run[i]));
    check_output($sformatf("u%0d_done", i), 32'(dn), 32'(m_done[i]));
    check_output($sformatf("u%0d_count", i), cnt, ec);
  endtask

  always @(posedge clk) begin
    model_step(0);
    model_step(1);
    #1;
    if (chk_en) begin
      check_inst(0, {cin4, a4, b4}, valid4, busy4, done4, cnt4);
      check_inst(1, {cinl, al, bl}, validl, busyl, donel, cntl);
    end
  end

  task automatic apply_stimulus(input logic m, input logic h);
    start = 1'b1; mode = m; hold = h;
    @(negedge clk);
    start = 1'b0; hold = 1'b0;
  endtask

  task automatic wait_count4(input logic [31:0] target, input int bound);
    int c = 0;
    while (cnt4 != target && c < bound) begin
      @(negedge clk);
      c++;
    end
    check_output("wait_count", cnt4, target);
  endtask

  task automatic random_run(input string tag);
    logic [8:0] caps [4];
    int n_valid = 0;
    int c = 0;
    for (int j = 0; j < 4; j++) caps[j] = 9'h1AA;
    apply_stimulus(1'b1, 1'b0);
    while (!done4 && c < 50) begin
      if (valid4) begin
        if (n_valid < 4) caps[n_valid] = {cin4, a4, b4};
        n_valid++;
      end
      @(negedge clk);
      c++;
    end
    check_output({tag, "_done"}, 32'(done4), 32'h1);
    check_output({tag, "_nvalid"}, 32'(n_valid), 32'd4);
    check_output({tag, "_v0"}, 32'(caps[0]), 32'h001);
    check_output({tag, "_v1"}, 32'(caps[1]), 32'h003);
    check_output({tag, "_v2"}, 32'(caps[2]), 32'h002);
    check_output({tag, "_v3"}, 32'(caps[3]), 32'h001);
  endtask

  initial begin
    logic [31:0] s;
    logic [8:0]  cap17;
    int          n_valid;
    int          c;

    s = 32'h0000_0001;
    for (int k = 0; k < 300; k++) begin
      lfsr_tab[k] = s;
      s = (s >> 1) ^ (s[0] ? 32'h8020_0003 : 32'h0);
    end
    check_output("model_lfsr0", 32'(lfsr_tab[0][8:0]), 32'h001);
    check_output("model_lfsr1", 32'(lfsr_tab[1][8:0]), 32'h003);

    rst_n = 1'b0; start = 1'b1; mode = 1'b0; hold = 1'b0;
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    check_output("reset_vec", 32'({cin4, a4, b4}), 32'h0);
    check_output("reset_flags", 32'({valid4, busy4, done4}), 32'h0);
    check_output("reset_count", cnt4, 32'h0);
    rst_n = 1'b1; start = 1'b0;

    $display("[TB] exhaustive sweep");
    apply_stimulus(1'b0, 1'b0);
    n_valid = 0; c = 0; cap17 = 9'h1AA;
    while (!done4 && c < 2000) begin
      if (valid4) begin
        n_valid++;
        if (cnt4 == 32'd18) cap17 = {cin4, a4, b4};
      end
      @(negedge clk);
      c++;
    end
    check_output("ex_nvalid", 32'(n_valid), 32'd512);
    check_output("ex_v17", 32'(cap17), 32'h011);
    check_output("ex_done", 32'(done4), 32'h1);
    check_output("ex_valid_off", 32'(valid4), 32'h0);
    check_output("ex_count", cnt4, 32'd512);
    check_output("ex_last_vec", 32'({cin4, a4, b4}), 32'h1FF);

    $display("[TB] random runs");
    random_run("rnd_a");
    random_run("rnd_b");

    $display("[TB] hold");
    apply_stimulus(1'b0, 1'b0);
    wait_count4(32'd6, 20);
    hold = 1'b1;
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      check_output("hold_valid", 32'(valid4), 32'h0);
      check_output("hold_vec", 32'({cin4, a4, b4}), 32'h005);
    end
    check_output("hold_count", cnt4, 32'd6);
    hold = 1'b0;
    @(negedge clk);
    check_output("resume_valid", 32'(valid4), 32'h1);
    check_output("resume_count", cnt4, 32'd7);
    check_output("resume_vec", 32'({cin4, a4, b4}), 32'h006);

    $display("[TB] abort");
    wait_count4(32'd101, 300);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check_output("abort_vec", 32'({cin4, a4, b4}), 32'h0);
    check_output("abort_flags", 32'({valid4, busy4, done4}), 32'h0);
    check_output("abort_count", cnt4, 32'h0);
    apply_stimulus(1'b0, 1'b1);
    check_output("restart_valid", 32'(valid4), 32'h1);
    check_output("restart_busy", 32'(busy4), 32'h1);
    check_output("restart_count", cnt4, 32'd1);
    check_output("restart_vec", 32'({cin4, a4, b4}), 32'h0);

    $display("[TB] randomized phase");
    for (int j = 0; j < 4000; j++) begin
      start = ($urandom_range(0, 7) == 0);
      mode  = 1'($urandom_range(0, 1));
      hold  = ($urandom_range(0, 3) == 0);
      rst_n = ($urandom_range(0, 299) != 0);
      @(negedge clk);
    end
    rst_n = 1'b1; start = 1'b0; hold = 1'b0;
    repeat (2) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
